instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_pkg.sv | 27 ++
 rtl/instr_fetch_ctrl_fifo2.sv | 66 ++++++
 rtl/instr_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and sizing for the instruction fetch controller.
package instr_fetch_ctrl_pkg;

   localparam int unsigned INSTR_W    = 16;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHalted
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Next sequential word address; wraps silently at the top of the space.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fifo2.sv
// fetch_fifo2: two-entry {pc, instr} buffer between fetch and decode.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle. Flush empties the buffer and wins over any push/pop.
module fetch_fifo2
   import instr_fetch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   input  logic               flush,
   output logic [CNT_W-1:0]   count,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [INSTR_W-1:0] head_instr
);

   fetch_entry_t     entry_q [FIFO_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic pop_ok;
   logic push_ok;

   // Qualify requests so a stray pop on empty or push on full cannot corrupt state.
   always_comb begin
      pop_ok  = pop && (count_q != '0);
      push_ok = push && ((count_q != FULL_CNT) || pop_ok);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            entry_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count      = count_q;
   assign head_pc    = entry_q[rd_ptr_q].pc;
   assign head_instr = entry_q[rd_ptr_q].instr;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequential instruction fetch with a 2-entry output buffer,
// redirect/flush, and halt/resume control.
// Optional feature: define IFETCH_PERF_EN to add the fetch_count output.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt_req,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               busy
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   fetch_state_e      state_q;
   logic              busy_q;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  count;

   logic pop;
   logic fetch;
   logic flush;

   // Buffer handshake, fetch qualification and redirect flush.
   always_comb begin
      out_valid = (count != '0);
      pop       = out_valid && out_ready;
      flush     = redirect_valid && (state_q != StIdle);
      fetch     = (state_q == StRun) && !redirect_valid &&
                  ((count != FULL_CNT) || pop);
   end

   // Control FSM; busy is registered alongside the state it reflects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               // halt wins over start; a concurrent redirect still lands via pc/flush
               if (halt_req) begin
                  state_q <= StHalted;
                  busy_q  <= 1'b0;
               end
            end
            StHalted: begin
               if (start || redirect_valid) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Program counter: redirect loads in every state, otherwise advance on fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= redirect_pc;
      end else if (fetch) begin
         pc_q <= pc_inc(pc_q);
      end
   end

   fetch_fifo2 u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fetch),
      .push_pc    (pc_q),
      .push_instr (imem_data),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head_pc    (out_pc),
      .head_instr (out_instr)
   );

   assign imem_addr = pc_q;
   assign busy      = busy_q;

`ifdef IFETCH_PERF_EN
   logic [15:0] fetch_count_q;

   // Push counter; only reset clears it, redirects do not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q <= '0;
      end else if (fetch) begin
         fetch_count_q <= fetch_count_q + 16'd1;
      end
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl. Memory word k holds 16'h1000 + k.
module tb_instr_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        halt_req;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        busy;
`ifdef IFETCH_PERF_EN
   logic [15:0] fetch_count;
`endif

   int n_vec;
   int n_err;

   instr_fetch_ctrl #(
      .RESET_PC (16'h0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .busy           (busy)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   assign imem_data = 16'h1000 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid actual=%b expected=0", out_valid);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy actual=%b expected=0", busy);
      end
      n_vec++;
      if (imem_addr !== 16'h0000) begin
         n_err++; $display("FAIL reset_addr actual=%h expected=0000", imem_addr);
      end
      n_vec++;
      if (out_pc !== 16'h0000 || out_instr !== 16'h0000) begin
         n_err++; $display("FAIL reset_head actual=%h/%h expected=0000/0000", out_pc, out_instr);
      end
`ifdef IFETCH_PERF_EN
      n_vec++;
      if (fetch_count !== 16'h0000) begin
         n_err++; $display("FAIL reset_fcnt actual=%h expected=0000", fetch_count);
      end
`endif
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_start();
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL start_run actual=busy%b/v%b/a%h expected=busy1/v0/a0000",
                  busy, out_valid, imem_addr);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 16'(k) || out_instr !== 16'h1000 + 16'(k)) begin
            n_err++;
            $display("FAIL start_seq%0d actual=v%b/%h/%h expected=v1/%h/%h", k, out_valid,
                     out_pc, out_instr, 16'(k), 16'h1000 + 16'(k));
         end
         if (k < 3) tick();
      end
   endtask

   task automatic test_backpressure();
      // head 3 on display but not accepted this cycle
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 16'h0003 || imem_addr !== 16'h0005) begin
            n_err++;
            $display("FAIL bp_hold%0d actual=v%b/%h/a%h expected=v1/0003/a0005", c, out_valid,
                     out_pc, imem_addr);
         end
      end
      out_ready = 1'b1;
      for (int k = 3; k < 6; k++) begin
         n_vec++;
         if (out_pc !== 16'(k) || out_instr !== 16'h1000 + 16'(k)) begin
            n_err++;
            $display("FAIL bp_drain%0d actual=%h/%h expected=%h/%h", k, out_pc, out_instr,
                     16'(k), 16'h1000 + 16'(k));
         end
         tick();
      end
      n_vec++;
      if (out_pc !== 16'h0006 || imem_addr !== 16'h0008) begin
         n_err++; $display("FAIL bp_steady actual=%h/a%h expected=0006/a0008", out_pc, imem_addr);
      end
`ifdef IFETCH_PERF_EN
      n_vec++;
      if (fetch_count !== 16'd8) begin
         n_err++; $display("FAIL bp_fcnt actual=%0d expected=8", fetch_count);
      end
`endif
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0006) begin
         n_err++; $display("FAIL rd_popped actual=v%b/%h expected=v1/0006", out_valid, out_pc);
      end
      tick();
      redirect_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || imem_addr !== 16'h0040) begin
         n_err++; $display("FAIL rd_flush actual=v%b/a%h expected=v0/a0040", out_valid, imem_addr);
      end
`ifdef IFETCH_PERF_EN
      n_vec++;
      if (fetch_count !== 16'd8) begin
         n_err++; $display("FAIL rd_fcnt actual=%0d expected=8", fetch_count);
      end
`endif
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 16'h1040) begin
         n_err++;
         $display("FAIL rd_target actual=v%b/%h/%h expected=v1/0040/1040", out_valid, out_pc,
                  out_instr);
      end
      tick();
      n_vec++;
      if (out_pc !== 16'h0041) begin
         n_err++; $display("FAIL rd_next actual=%h expected=0041", out_pc);
      end
   endtask

   task automatic test_halt();
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0003;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || imem_addr !== 16'h0005 || out_pc !== 16'h0003) begin
         n_err++;
         $display("FAIL halt_enter actual=busy%b/a%h/%h expected=busy0/a0005/0003", busy,
                  imem_addr, out_pc);
      end
      out_ready = 1'b1;
      for (int k = 3; k < 5; k++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 16'(k)) begin
            n_err++;
            $display("FAIL halt_drain%0d actual=v%b/%h expected=v1/%h", k, out_valid, out_pc,
                     16'(k));
         end
         tick();
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || imem_addr !== 16'h0005 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL halt_idle actual=v%b/a%h/busy%b expected=v0/a0005/busy0", out_valid,
                  imem_addr, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL halt_resume actual=busy%b/v%b expected=busy1/v0", busy, out_valid);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0005 || out_instr !== 16'h1005) begin
         n_err++;
         $display("FAIL halt_first actual=v%b/%h/%h expected=v1/0005/1005", out_valid, out_pc,
                  out_instr);
      end
      tick();
      n_vec++;
      if (out_pc !== 16'h0006) begin
         n_err++; $display("FAIL halt_second actual=%h expected=0006", out_pc);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_vec++;
      if (out_pc !== 16'hFFFF || out_instr !== 16'h0FFF) begin
         n_err++; $display("FAIL wrap_ffff actual=%h/%h expected=ffff/0fff", out_pc, out_instr);
      end
      tick();
      n_vec++;
      if (out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
         n_err++; $display("FAIL wrap_0000 actual=%h/%h expected=0000/1000", out_pc, out_instr);
      end
      tick();
      n_vec++;
      if (out_pc !== 16'h0001 || busy !== 1'b1) begin
         n_err++; $display("FAIL wrap_0001 actual=%h/busy%b expected=0001/busy1", out_pc, busy);
      end
   endtask

   task automatic test_halt_redirect();
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0020;
      tick();
      halt_req = 1'b0;
      redirect_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 16'h0020) begin
         n_err++;
         $display("FAIL hr_both actual=busy%b/v%b/a%h expected=busy0/v0/a0020", busy, out_valid,
                  imem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0030;
      tick();
      redirect_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 16'h0030) begin
         n_err++;
         $display("FAIL hr_resume actual=busy%b/v%b/a%h expected=busy1/v0/a0030", busy,
                  out_valid, imem_addr);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0030) begin
         n_err++; $display("FAIL hr_first actual=v%b/%h expected=v1/0030", out_valid, out_pc);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || imem_addr !== 16'h0000 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL ar_now actual=v%b/a%h/busy%b expected=v0/a0000/busy0", out_valid,
                  imem_addr, busy);
      end
`ifdef IFETCH_PERF_EN
      n_vec++;
      if (fetch_count !== 16'h0000) begin
         n_err++; $display("FAIL ar_fcnt actual=%h expected=0000", fetch_count);
      end
`endif
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL ar_after actual=v%b/busy%b/a%h expected=v0/busy0/a0000", out_valid,
                  busy, imem_addr);
      end
   endtask

   task automatic test_idle_redirect();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 16'h0010) begin
         n_err++;
         $display("FAIL idle_rd actual=busy%b/v%b/a%h expected=busy0/v0/a0010", busy, out_valid,
                  imem_addr);
      end
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst            = 1'b1;
      start          = 1'b0;
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      out_ready      = 1'b0;
      test_reset();
      test_start();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_halt_redirect();
      test_async_reset();
      test_idle_redirect();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
